// File: rtl/stn2tft_pkg.sv
// Shared definitions for the STN-to-TFT bridge: frame RAM geometry,
// default panel size, capture FSM states and the write-buffer entry type.
package stn2tft_pkg;

    localparam int unsigned RAM_AW      = 13;
    localparam int unsigned RAM_BYTES   = 6144;
    localparam int unsigned H_BYTES_DEF = 40;
    localparam int unsigned V_LINES_DEF = 150;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        CAPTURE    = 1'b1
    } cap_state_t;

    typedef struct packed {
        logic [RAM_AW-1:0] addr;
        logic [7:0]        data;
    } wr_entry_t;

endpackage

// File: rtl/stn_cap_fifo.sv
// Synchronous write buffer between the capture FSM and the frame RAM arbiter.
// Simultaneous push and pop while full are both honoured.
module stn_cap_fifo
    import stn2tft_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wr_entry_t push_entry,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    wr_entry_t     mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[PW-1:0]] <= push_entry;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stn_capture.sv
// STN panel capture front-end: samples FPFRAME/FPLINE/FPSHIFT/FPDAT, packs
// nibble pairs into frame RAM writes. Define STN_CAP_SYNC_EN for 2-flop input sync.
module stn_capture
    import stn2tft_pkg::*;
#(
    parameter int unsigned H_BYTES    = H_BYTES_DEF,
    parameter int unsigned V_LINES    = V_LINES_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stn_fpframe,
    input  logic              stn_fpline,
    input  logic              stn_fpshift,
    input  logic [3:0]        stn_fpdat,
    output logic              wr_req,
    output logic [RAM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ack,
    output logic              frame_start,
    output logic              capturing,
    output logic              ovf,
    output logic              fmt_err,
    input  logic              err_clr
);

    localparam logic [RAM_AW-1:0] H_BYTES_W = RAM_AW'(H_BYTES);
    localparam logic [RAM_AW-1:0] V_LINES_W = RAM_AW'(V_LINES);

    logic [6:0] pins;
    logic [6:0] sync;
    logic [2:0] prev_ctl;

    assign pins = {stn_fpframe, stn_fpline, stn_fpshift, stn_fpdat};

`ifdef STN_CAP_SYNC_EN
    logic [6:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= pins;
            sync <= meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= pins;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ctl <= '0;
        end else begin
            prev_ctl <= sync[6:4];
        end
    end

    logic       fall_shift;
    logic       rise_line;
    logic       rise_frame;
    logic [3:0] nibble;

    assign fall_shift = prev_ctl[0] && !sync[4];
    assign rise_line  = sync[5] && !prev_ctl[1];
    assign rise_frame = sync[6] && !prev_ctl[2];
    assign nibble     = sync[3:0];

    cap_state_t        state;
    logic [RAM_AW-1:0] line;
    logic [RAM_AW-1:0] line_base;
    logic [RAM_AW-1:0] byte_idx;
    logic              half;
    logic [3:0]        data_hi;
    logic              push_q;
    wr_entry_t         push_entry;

    logic              active;
    logic              sh_push;
    logic              fmt_set;
    logic              n_half;
    logic [RAM_AW-1:0] n_idx;
    logic [3:0]        n_hi;

    // Shift is resolved first so a nibble arriving with the line pulse still
    // belongs to the ending line; a frame pulse discards both.
    always_comb begin
        active  = (state == CAPTURE) && !rise_frame;
        sh_push = 1'b0;
        fmt_set = 1'b0;
        n_half  = half;
        n_idx   = byte_idx;
        n_hi    = data_hi;
        if (active && fall_shift) begin
            if (!half) begin
                n_hi   = nibble;
                n_half = 1'b1;
            end else begin
                n_half = 1'b0;
                if (byte_idx < H_BYTES_W) begin
                    sh_push = 1'b1;
                    n_idx   = byte_idx + 1'b1;
                end else begin
                    fmt_set = 1'b1;
                end
            end
        end
        if (active && rise_line && n_half) begin
            fmt_set = 1'b1;
        end
    end

    wr_entry_t head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      pop;
    logic      ovf_set;

    assign pop     = wr_ack && !fifo_empty;
    assign ovf_set = push_q && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_FRAME;
            line        <= '0;
            line_base   <= '0;
            byte_idx    <= '0;
            half        <= 1'b0;
            data_hi     <= '0;
            push_q      <= 1'b0;
            push_entry  <= '0;
            frame_start <= 1'b0;
            ovf         <= 1'b0;
            fmt_err     <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            push_q      <= 1'b0;
            if (rise_frame) begin
                state       <= CAPTURE;
                line        <= '0;
                line_base   <= '0;
                byte_idx    <= '0;
                half        <= 1'b0;
                frame_start <= 1'b1;
            end else if (state == CAPTURE) begin
                half            <= n_half;
                byte_idx        <= n_idx;
                data_hi         <= n_hi;
                push_q          <= sh_push;
                push_entry.addr <= line_base + byte_idx;
                push_entry.data <= {data_hi, nibble};
                if (rise_line) begin
                    half      <= 1'b0;
                    byte_idx  <= '0;
                    line_base <= line_base + H_BYTES_W;
                    line      <= line + 1'b1;
                    if (line + 1'b1 == V_LINES_W) begin
                        state <= WAIT_FRAME;
                    end
                end
            end

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (err_clr) begin
                ovf <= 1'b0;
            end
            if (fmt_set) begin
                fmt_err <= 1'b1;
            end else if (err_clr) begin
                fmt_err <= 1'b0;
            end
        end
    end

    assign capturing = (state == CAPTURE);

    stn_cap_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_q),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign wr_req  = !fifo_empty;
    assign wr_addr = head.addr;
    assign wr_data = head.data;

endmodule
